// File: rtl/mips_decode_mem_unit_pkg.sv
// Shared opcode, function-select and mux encodings for the decode/memory unit.
// Optional feature macro: DMEM_RESET_CLEAR_EN (reset zeroes data memory).
package mips_decode_mem_unit_pkg;

    localparam int DMEM_AW_DEF = 8;

    // md encodings
    localparam logic [1:0] MD_FUNC = 2'b00;
    localparam logic [1:0] MD_MEM  = 2'b01;
    localparam logic [1:0] MD_SLT  = 2'b10;

    // bs encodings
    localparam logic [1:0] BS_NEXT = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_JREG = 2'b10;
    localparam logic [1:0] BS_JREL = 2'b11;

    // fs codes
    localparam logic [4:0] FS_MOVA = 5'b00000;
    localparam logic [4:0] FS_ADD  = 5'b00010;
    localparam logic [4:0] FS_SUB  = 5'b00101;
    localparam logic [4:0] FS_AND  = 5'b01000;
    localparam logic [4:0] FS_OR   = 5'b01001;
    localparam logic [4:0] FS_XOR  = 5'b01010;
    localparam logic [4:0] FS_NOT  = 5'b01011;
    localparam logic [4:0] FS_MOVB = 5'b01100;
    localparam logic [4:0] FS_LSR  = 5'b10100;
    localparam logic [4:0] FS_LSL  = 5'b11000;

    // opcodes
    localparam logic [6:0] OP_NOP  = 7'b0000000;
    localparam logic [6:0] OP_MOVA = 7'b1000000;
    localparam logic [6:0] OP_ADD  = 7'b0000010;
    localparam logic [6:0] OP_SUB  = 7'b0000101;
    localparam logic [6:0] OP_AND  = 7'b0001000;
    localparam logic [6:0] OP_OR   = 7'b0001001;
    localparam logic [6:0] OP_XOR  = 7'b0001010;
    localparam logic [6:0] OP_NOT  = 7'b0001011;
    localparam logic [6:0] OP_MOVB = 7'b0001100;
    localparam logic [6:0] OP_LSR  = 7'b0001101;
    localparam logic [6:0] OP_LSL  = 7'b0001110;
    localparam logic [6:0] OP_ADI  = 7'b0100010;
    localparam logic [6:0] OP_SBI  = 7'b0100101;
    localparam logic [6:0] OP_ANI  = 7'b0101000;
    localparam logic [6:0] OP_ORI  = 7'b0101001;
    localparam logic [6:0] OP_XRI  = 7'b0101010;
    localparam logic [6:0] OP_AIU  = 7'b1000010;
    localparam logic [6:0] OP_SIU  = 7'b1000101;
    localparam logic [6:0] OP_LD   = 7'b0010000;
    localparam logic [6:0] OP_ST   = 7'b0100000;
    localparam logic [6:0] OP_SLT  = 7'b1100101;
    localparam logic [6:0] OP_BZ   = 7'b1100000;
    localparam logic [6:0] OP_BNZ  = 7'b1001000;
    localparam logic [6:0] OP_JMR  = 7'b1110000;
    localparam logic [6:0] OP_JMP  = 7'b1101000;
    localparam logic [6:0] OP_JML  = 7'b0110000;

    typedef struct packed {
        logic       ma;
        logic       mb;
        logic       cs;
        logic       rw;
        logic       ps;
        logic       mw;
        logic [1:0] md;
        logic [1:0] bs;
        logic [4:0] fs;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_MOVA: begin c.fs = FS_MOVA; c.rw = 1'b1; end
            OP_ADD:  begin c.fs = FS_ADD;  c.rw = 1'b1; end
            OP_SUB:  begin c.fs = FS_SUB;  c.rw = 1'b1; end
            OP_AND:  begin c.fs = FS_AND;  c.rw = 1'b1; end
            OP_OR:   begin c.fs = FS_OR;   c.rw = 1'b1; end
            OP_XOR:  begin c.fs = FS_XOR;  c.rw = 1'b1; end
            OP_NOT:  begin c.fs = FS_NOT;  c.rw = 1'b1; end
            OP_MOVB: begin c.fs = FS_MOVB; c.rw = 1'b1; end
            OP_LSR:  begin c.fs = FS_LSR;  c.rw = 1'b1; end
            OP_LSL:  begin c.fs = FS_LSL;  c.rw = 1'b1; end
            OP_ADI:  begin c.fs = FS_ADD;  c.rw = 1'b1; c.mb = 1'b1; c.cs = 1'b1; end
            OP_SBI:  begin c.fs = FS_SUB;  c.rw = 1'b1; c.mb = 1'b1; c.cs = 1'b1; end
            OP_ANI:  begin c.fs = FS_AND;  c.rw = 1'b1; c.mb = 1'b1; end
            OP_ORI:  begin c.fs = FS_OR;   c.rw = 1'b1; c.mb = 1'b1; end
            OP_XRI:  begin c.fs = FS_XOR;  c.rw = 1'b1; c.mb = 1'b1; end
            OP_AIU:  begin c.fs = FS_ADD;  c.rw = 1'b1; c.mb = 1'b1; end
            OP_SIU:  begin c.fs = FS_SUB;  c.rw = 1'b1; c.mb = 1'b1; end
            OP_LD:   begin c.md = MD_MEM;  c.rw = 1'b1; end
            OP_ST:   begin c.mw = 1'b1; end
            OP_SLT:  begin c.fs = FS_SUB;  c.md = MD_SLT; c.rw = 1'b1; end
            OP_BZ:   begin c.bs = BS_COND; c.mb = 1'b1; c.cs = 1'b1; end
            OP_BNZ:  begin c.bs = BS_COND; c.ps = 1'b1; c.mb = 1'b1; c.cs = 1'b1; end
            OP_JMR:  begin c.bs = BS_JREG; end
            OP_JMP:  begin c.bs = BS_JREL; c.mb = 1'b1; c.cs = 1'b1; end
            OP_JML:  begin c.bs = BS_JREL; c.mb = 1'b1; c.cs = 1'b1; c.ma = 1'b1; c.rw = 1'b1;
                           c.fs = FS_MOVA; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_decode_mem_unit_dmem.sv
// Data memory: async read, sync write, reset blocks writes.
// With DMEM_RESET_CLEAR_EN defined, reset also clears every word.
module mips_dmem_core #(
    parameter int DMEM_AW = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               we,
    input  logic [DMEM_AW-1:0] addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata
);

    localparam int DEPTH = 2 ** DMEM_AW;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
`ifdef DMEM_RESET_CLEAR_EN
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[addr] <= wdata;
        end
`else
        if (reset && we) mem[addr] <= wdata;
`endif
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mips_decode_mem_unit.sv
// Instruction decode, immediate extension and data memory for a simple MIPS-like pipeline.
// Optional feature macro: DMEM_RESET_CLEAR_EN (handled in mips_dmem_core).
module mips_decode_mem_unit
    import mips_decode_mem_unit_pkg::*;
#(
    parameter int DMEM_AW = DMEM_AW_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    output logic        ma,
    output logic        mb,
    output logic        cs,
    output logic        rw,
    output logic        ps,
    output logic        mw,
    output logic [4:0]  aa,
    output logic [4:0]  ba,
    output logic [4:0]  da,
    output logic [1:0]  md,
    output logic [1:0]  bs,
    output logic [4:0]  fs,
    output logic [31:0] const_out,
    output logic [31:0] mem_rdata
);

    ctrl_t ctrl;

    always_comb begin
        ctrl = decode_op(instr[31:25]);
    end

    assign ma = ctrl.ma;
    assign mb = ctrl.mb;
    assign cs = ctrl.cs;
    assign rw = ctrl.rw;
    assign ps = ctrl.ps;
    assign mw = ctrl.mw;
    assign md = ctrl.md;
    assign bs = ctrl.bs;
    assign fs = ctrl.fs;

    assign da = instr[24:20];
    assign aa = instr[19:15];
    assign ba = instr[14:10];

    assign const_out = {{17{ctrl.cs & instr[14]}}, instr[14:0]};

    // Upper address bits are intentionally ignored so the memory wraps.
    logic addr_unused;
    assign addr_unused = ^mem_addr[31:DMEM_AW];

    mips_dmem_core #(.DMEM_AW(DMEM_AW)) u_dmem (
        .clock (clock),
        .reset (reset),
        .we    (mem_we),
        .addr  (mem_addr[DMEM_AW-1:0]),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mips_decode_mem_unit.sv
// Directed self-checking bench for mips_decode_mem_unit (decode table, immediates, memory, reset).
module tb_mips_decode_mem_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        ma, mb, cs, rw, ps, mw;
    logic [4:0]  aa, ba, da, fs;
    logic [1:0]  md, bs;
    logic [31:0] const_out, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mips_decode_mem_unit #(.DMEM_AW(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .instr     (instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .ma        (ma),
        .mb        (mb),
        .cs        (cs),
        .rw        (rw),
        .ps        (ps),
        .mw        (mw),
        .aa        (aa),
        .ba        (ba),
        .da        (da),
        .md        (md),
        .bs        (bs),
        .fs        (fs),
        .const_out (const_out),
        .mem_rdata (mem_rdata)
    );

    // {ma,mb,cs,rw,ps,mw,md,bs,fs}
    logic [14:0] ctl;
    assign ctl = {ma, mb, cs, rw, ps, mw, md, bs, fs};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b0; instr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_we = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_cmp++;
        if (ctl !== 15'b0 || const_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_nop: ctl=%b const=%h want ctl=0 const=0", ctl, const_out);
        end
        // decode stays live while reset is held
        instr = 32'h0430_8800;
        #1;
        n_cmp++;
        if (fs !== 5'b00010 || rw !== 1'b1) begin
            n_err++;
            $display("FAIL reset_decode_live: fs=%b rw=%b want fs=00010 rw=1", fs, rw);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_add_fields();
        instr = 32'h0430_8800;  // ADD DR=3 SA=1 SB=2
        #1;
        n_cmp++;
        if (fs !== 5'b00010 || rw !== 1'b1 || md !== 2'b00 || mb !== 1'b0 ||
            da !== 5'd3 || aa !== 5'd1 || ba !== 5'd2) begin
            n_err++;
            $display("FAIL add_fields: fs=%b rw=%b md=%b mb=%b da=%0d aa=%0d ba=%0d want 00010 1 00 0 3 1 2",
                     fs, rw, md, mb, da, aa, ba);
        end
    endtask

    task automatic test_decode_table();
        logic [6:0]  ops  [19];
        logic [14:0] want [19];
        ops[0]  = 7'b1000000; want[0]  = 15'b0_0_0_1_0_0_00_00_00000; // MOVA
        ops[1]  = 7'b0000101; want[1]  = 15'b0_0_0_1_0_0_00_00_00101; // SUB
        ops[2]  = 7'b0001011; want[2]  = 15'b0_0_0_1_0_0_00_00_01011; // NOT
        ops[3]  = 7'b0001101; want[3]  = 15'b0_0_0_1_0_0_00_00_10100; // LSR
        ops[4]  = 7'b0001110; want[4]  = 15'b0_0_0_1_0_0_00_00_11000; // LSL
        ops[5]  = 7'b0100010; want[5]  = 15'b0_1_1_1_0_0_00_00_00010; // ADI
        ops[6]  = 7'b0101000; want[6]  = 15'b0_1_0_1_0_0_00_00_01000; // ANI
        ops[7]  = 7'b0101010; want[7]  = 15'b0_1_0_1_0_0_00_00_01010; // XRI
        ops[8]  = 7'b1000010; want[8]  = 15'b0_1_0_1_0_0_00_00_00010; // AIU
        ops[9]  = 7'b0010000; want[9]  = 15'b0_0_0_1_0_0_01_00_00000; // LD
        ops[10] = 7'b0100000; want[10] = 15'b0_0_0_0_0_1_00_00_00000; // ST
        ops[11] = 7'b1100101; want[11] = 15'b0_0_0_1_0_0_10_00_00101; // SLT
        ops[12] = 7'b1100000; want[12] = 15'b0_1_1_0_0_0_00_01_00000; // BZ
        ops[13] = 7'b1001000; want[13] = 15'b0_1_1_0_1_0_00_01_00000; // BNZ
        ops[14] = 7'b1110000; want[14] = 15'b0_0_0_0_0_0_00_10_00000; // JMR
        ops[15] = 7'b1101000; want[15] = 15'b0_1_1_0_0_0_00_11_00000; // JMP
        ops[16] = 7'b0110000; want[16] = 15'b1_1_1_1_0_0_00_11_00000; // JML
        ops[17] = 7'b0000000; want[17] = 15'b0;                       // NOP
        ops[18] = 7'b1111111; want[18] = 15'b0;                       // unlisted
        for (int i = 0; i < 19; i++) begin
            instr = {ops[i], 25'h0};
            #1;
            n_cmp++;
            if (ctl !== want[i]) begin
                n_err++;
                $display("FAIL decode_op_%b: ctl=%b want %b", ops[i], ctl, want[i]);
            end
        end
    endtask

    task automatic test_const();
        logic [31:0] ins  [4];
        logic [31:0] want [4];
        ins[0] = {7'b0100010, 10'h0, 15'h7FFF}; want[0] = 32'hFFFF_FFFF; // ADI sign-extends
        ins[1] = {7'b0101000, 10'h0, 15'h7FFF}; want[1] = 32'h0000_7FFF; // ANI zero-extends
        ins[2] = {7'b0100010, 10'h0, 15'h1234}; want[2] = 32'h0000_1234; // ADI positive
        ins[3] = {7'b1100000, 10'h0, 15'h4000}; want[3] = 32'hFFFF_C000; // BZ negative offset
        for (int i = 0; i < 4; i++) begin
            instr = ins[i];
            #1;
            n_cmp++;
            if (const_out !== want[i]) begin
                n_err++;
                $display("FAIL const_%0d: const_out=%h want %h", i, const_out, want[i]);
            end
        end
        instr = ins[0];
        #1;
        n_cmp++;
        if (mb !== 1'b1 || cs !== 1'b1) begin
            n_err++;
            $display("FAIL adi_mb_cs: mb=%b cs=%b want 1 1", mb, cs);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        mem_we = 1'b1; mem_addr = a; mem_wdata = d;
        @(negedge clock);
        mem_we = 1'b0;
    endtask

    task automatic test_mem_write();
        do_write(32'd5, 32'hDEAD_BEEF);
        mem_addr = 32'd5;
        #1;
        n_cmp++;
        if (mem_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL mem_rd5: got %h want deadbeef", mem_rdata);
        end
        mem_addr = 32'h105;
        #1;
        n_cmp++;
        if (mem_rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL mem_wrap_105: got %h want deadbeef", mem_rdata);
        end
    endtask

    task automatic test_read_during_write();
        do_write(32'd7, 32'h1111_1111);
        @(negedge clock);
        mem_we = 1'b1; mem_addr = 32'd7; mem_wdata = 32'h2222_2222;
        #1;
        n_cmp++;
        if (mem_rdata !== 32'h1111_1111) begin
            n_err++;
            $display("FAIL rdw_old: got %h want 11111111", mem_rdata);
        end
        @(negedge clock);
        mem_we = 1'b0;
        #1;
        n_cmp++;
        if (mem_rdata !== 32'h2222_2222) begin
            n_err++;
            $display("FAIL rdw_new: got %h want 22222222", mem_rdata);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        mem_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_addr = 32'd10 + 32'(i);
            mem_wdata = 32'hA000_0000 + 32'(i * 3);
            @(negedge clock);
        end
        mem_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_addr = 32'd10 + 32'(i);
            #1;
            n_cmp++;
            if (mem_rdata !== 32'hA000_0000 + 32'(i * 3)) begin
                n_err++;
                $display("FAIL b2b_%0d: got %h want %h", i, mem_rdata, 32'hA000_0000 + 32'(i * 3));
            end
        end
    endtask

    task automatic test_reset_blocks_write();
        logic [31:0] want6, want5;
        do_write(32'd6, 32'h6666_6666);
        @(negedge clock);
        reset = 1'b0; mem_we = 1'b1; mem_addr = 32'd6; mem_wdata = 32'hBAD0_BAD0;
        @(negedge clock);
        reset = 1'b1; mem_we = 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
        want6 = 32'h0; want5 = 32'h0;
`else
        want6 = 32'h6666_6666; want5 = 32'hDEAD_BEEF;
`endif
        #1;
        n_cmp++;
        if (mem_rdata !== want6) begin
            n_err++;
            $display("FAIL rst_blocks_wr6: got %h want %h", mem_rdata, want6);
        end
        mem_addr = 32'd5;
        #1;
        n_cmp++;
        if (mem_rdata !== want5) begin
            n_err++;
            $display("FAIL rst_word5: got %h want %h", mem_rdata, want5);
        end
    endtask

    initial begin
        test_reset();
        test_add_fields();
        test_decode_table();
        test_const();
        test_mem_write();
        test_read_during_write();
        test_back_to_back();
        test_reset_blocks_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
